// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline hazard controller.
//   state_t        : FSM state encodings (IDLE, BUSY, FLUSH)
//   STALL_BUS_W    : width of the per-stage hold vector (StallBus)
//   STALL_*        : bit index of each pipeline stage inside the hold vector
//   stall_upto()   : builds a hold vector freezing stages 0..last (front end up to 'last')
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int STALL_BUS_W = 6;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_RSVD   = 5;

    // Holding a stage only makes sense together with every stage in front of
    // it, so a hold request is always a contiguous run of ones from bit 0.
    function automatic logic [STALL_BUS_W-1:0] stall_upto(input int last);
        logic [STALL_BUS_W-1:0] v;
        v = '0;
        for (int i = 0; i < STALL_BUS_W; i++) begin
            if (i <= last) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall / flush controller.
// Arbitrates three hazard sources with priority flush_req > multi-cycle EX op
// > load-use stall, and tracks multi-cycle EX occupancy with a down-counter.
// Ports:
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-high reset
//   stallreq_id  : load-use hazard detected in ID this cycle
//   mc_start     : EX issues a multi-cycle op this cycle
//   mc_cycles    : total EX occupancy of that op, sampled with mc_start
//   flush_req    : exception / redirect request from MEM
//   flush_pc     : redirect target, sampled with flush_req
//   stall        : per-stage hold vector (pc, if_id, id_ex, ex_mem, mem_wb, rsvd)
//   flush        : clear all pipeline registers this cycle
//   new_pc       : PC to load while flush=1
//   mc_busy      : multi-cycle op in progress
//   mc_done      : one-cycle pulse in the final busy cycle
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int STALL_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                flush_req,
    input  logic [31:0]         flush_pc,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_busy,
    output logic                mc_done
);

    state_t                 state_reg, state_next;
    logic [MC_CNT_W-1:0]    cnt_reg, cnt_next;
    logic [31:0]            new_pc_reg;

    logic [STALL_BUS_W-1:0] stall_vec;
    logic                   busy_c;
    logic                   done_c;
    logic                   mc_long;
    logic                   busy_last;

    // Ops of 0 or 1 cycles complete inside the issuing cycle and never enter BUSY.
    assign mc_long = (mc_cycles > MC_CNT_W'(1));

    // The counter is decremented every BUSY cycle; this cycle is the last one
    // when the decremented value reaches zero.
    assign busy_last = (cnt_reg <= MC_CNT_W'(1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_vec  = '0;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        if (flush_req) begin
            // Redirect wins over everything: abort any op silently, no stall
            // so the pipeline can drain into the flush.
            state_next = FLUSH;
            cnt_next   = '0;
            busy_c     = (state_reg == BUSY);
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (mc_start && mc_long) begin
                        stall_vec  = stall_upto(STALL_EX_MEM);
                        busy_c     = 1'b1;
                        cnt_next   = mc_cycles - MC_CNT_W'(1);
                        state_next = BUSY;
                    end else begin
                        // A short op finishes now; a concurrent load-use
                        // hazard still needs its bubble.
                        done_c = mc_start;
                        if (stallreq_id) begin
                            stall_vec = stall_upto(STALL_ID_EX);
                        end
                    end
                end
                BUSY: begin
                    // mc_start and stallreq_id are ignored: the EX hold
                    // already freezes ID.
                    busy_c = 1'b1;
                    if (busy_last) begin
                        done_c     = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        stall_vec = stall_upto(STALL_EX_MEM);
                        cnt_next  = cnt_reg - MC_CNT_W'(1);
                    end
                end
                FLUSH: begin
                    // Pipeline is being cleared; nothing issued this cycle is real.
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            new_pc_reg <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (flush_req) begin
                new_pc_reg <= flush_pc;
            end
        end
    end

    // Outputs are qualified with rst so they drop the moment reset rises,
    // even while inputs still request stalls.
    generate
        for (genvar gi = 0; gi < STALL_W; gi++) begin : g_stall
            if (gi < STALL_BUS_W) begin : g_map
                assign stall[gi] = !rst && stall_vec[gi];
            end else begin : g_pad
                assign stall[gi] = 1'b0;
            end
        end
    endgenerate

    assign flush   = !rst && (state_reg == FLUSH);
    assign new_pc  = new_pc_reg;
    assign mc_busy = !rst && busy_c;
    assign mc_done = !rst && done_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// A behavioural model (remaining-busy-cycles count, pending-flush flag,
// redirect PC) predicts every output; a compare process checks it on each
// falling edge, and the directed sequence adds literal per-cycle expectations.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.MC_CNT_W(6), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
        .mc_cycles(mc_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .mc_busy(mc_busy), .mc_done(mc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_left;   // BUSY cycles still to come, current one included
    logic        m_flush;  // flush pulse due this cycle
    logic [31:0] m_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_flush <= 1'b0;
            m_pc    <= 32'h0;
        end else if (flush_req) begin
            m_left  <= 0;
            m_flush <= 1'b1;
            m_pc    <= flush_pc;
        end else begin
            m_flush <= 1'b0;
            if (m_left > 0)
                m_left <= m_left - 1;
            else if (!m_flush && mc_start && mc_cycles > 6'd1)
                m_left <= int'(mc_cycles) - 1;
        end
    end

    task automatic model_out(output logic [5:0] s, output logic b, output logic d,
                             output logic f, output logic [31:0] pc);
        s = 6'b000000; b = 1'b0; d = 1'b0; f = 1'b0; pc = m_pc;
        if (rst) begin
            pc = 32'h0;
        end else if (flush_req) begin
            b = (m_left > 0);
            f = m_flush;
        end else if (m_flush) begin
            f = 1'b1;
        end else if (m_left > 0) begin
            b = 1'b1;
            d = (m_left == 1);
            s = (m_left > 1) ? 6'b001111 : 6'b000000;
        end else if (mc_start && mc_cycles > 6'd1) begin
            b = 1'b1;
            s = 6'b001111;
        end else begin
            d = mc_start;
            s = stallreq_id ? 6'b000111 : 6'b000000;
        end
    endtask

    always @(negedge clk) begin
        logic [5:0]  es;
        logic        eb, ed, ef;
        logic [31:0] epc;
        model_out(es, eb, ed, ef, epc);
        checks++;
        if (stall !== es || mc_busy !== eb || mc_done !== ed || flush !== ef || new_pc !== epc) begin
            errors++;
            $display("FAIL model t=%0t: got stall=%b busy=%b done=%b flush=%b pc=%h, want stall=%b busy=%b done=%b flush=%b pc=%h",
                     $time, stall, mc_busy, mc_done, flush, new_pc, es, eb, ed, ef, epc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input logic [5:0] s, input logic b,
                       input logic d, input logic f, input logic [31:0] pc);
        checks++;
        if (stall !== s || mc_busy !== b || mc_done !== d || flush !== f || new_pc !== pc) begin
            errors++;
            $display("FAIL %s: got stall=%b busy=%b done=%b flush=%b pc=%h, want stall=%b busy=%b done=%b flush=%b pc=%h",
                     name, stall, mc_busy, mc_done, flush, new_pc, s, b, d, f, pc);
        end else begin
            $display("ok   %s: stall=%b busy=%b done=%b flush=%b pc=%h",
                     name, stall, mc_busy, mc_done, flush, new_pc);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge and return just
    // before the falling edge so literal checks see settled outputs.
    task automatic drive(input logic sr, input logic ms, input logic [5:0] mcc,
                         input logic fr, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        stallreq_id = sr;
        mc_start    = ms;
        mc_cycles   = mcc;
        flush_req   = fr;
        flush_pc    = fpc;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; mc_start = 1'b0; mc_cycles = 6'd0;
        flush_req = 1'b0; flush_pc = 32'h0;
        #2;
        lit("reset", 6'b000000, 0, 0, 0, 32'h0);
        @(posedge clk); @(posedge clk); #6;
        rst = 1'b0;

        // Load-use stall for two cycles
        drive(1, 0, 6'd0, 0, 32'h0); lit("ldu_c1", 6'b000111, 0, 0, 0, 32'h0);
        drive(1, 0, 6'd0, 0, 32'h0); lit("ldu_c2", 6'b000111, 0, 0, 0, 32'h0);
        idle();                      lit("ldu_end", 6'b000000, 0, 0, 0, 32'h0);

        // Four-cycle op; mc_start/stallreq_id during BUSY are ignored
        drive(0, 1, 6'd4, 0, 32'h0); lit("mc4_c1", 6'b001111, 1, 0, 0, 32'h0);
        drive(1, 1, 6'd9, 0, 32'h0); lit("mc4_c2", 6'b001111, 1, 0, 0, 32'h0);
        idle();                      lit("mc4_c3", 6'b001111, 1, 0, 0, 32'h0);
        idle();                      lit("mc4_c4", 6'b000000, 1, 1, 0, 32'h0);
        idle();                      lit("mc4_end", 6'b000000, 0, 0, 0, 32'h0);

        // Degenerate op lengths
        drive(0, 1, 6'd0, 0, 32'h0); lit("mc0", 6'b000000, 0, 1, 0, 32'h0);
        drive(0, 1, 6'd1, 0, 32'h0); lit("mc1", 6'b000000, 0, 1, 0, 32'h0);
        idle();                      lit("mc1_end", 6'b000000, 0, 0, 0, 32'h0);

        // Two-cycle op: one stall cycle, done in second
        drive(0, 1, 6'd2, 0, 32'h0); lit("mc2_c1", 6'b001111, 1, 0, 0, 32'h0);
        idle();                      lit("mc2_c2", 6'b000000, 1, 1, 0, 32'h0);

        // Flush on second BUSY cycle aborts the op
        drive(0, 1, 6'd5, 0, 32'h0);          lit("fb_start", 6'b001111, 1, 0, 0, 32'h0);
        idle();                               lit("fb_busy1", 6'b001111, 1, 0, 0, 32'h0);
        drive(0, 0, 6'd0, 1, 32'hBFC0_0380);  lit("fb_req", 6'b000000, 1, 0, 0, 32'h0);
        idle();                               lit("fb_flush", 6'b000000, 0, 0, 1, 32'hBFC0_0380);
        idle();                               lit("fb_after", 6'b000000, 0, 0, 0, 32'hBFC0_0380);
        idle();                               lit("fb_nodone", 6'b000000, 0, 0, 0, 32'hBFC0_0380);

        // Back-to-back flush requests re-enter FLUSH with the newer PC
        drive(0, 0, 6'd0, 1, 32'h0000_1000);  lit("ff_req1", 6'b000000, 0, 0, 0, 32'hBFC0_0380);
        drive(0, 0, 6'd0, 1, 32'h0000_2000);  lit("ff_req2", 6'b000000, 0, 0, 1, 32'h0000_1000);
        idle();                               lit("ff_fl2", 6'b000000, 0, 0, 1, 32'h0000_2000);
        idle();                               lit("ff_end", 6'b000000, 0, 0, 0, 32'h0000_2000);

        // All three requests together: flush wins, no BUSY entry
        drive(1, 1, 6'd4, 1, 32'h8000_0180); lit("all_req", 6'b000000, 0, 0, 0, 32'h0000_2000);
        idle();                              lit("all_flush", 6'b000000, 0, 0, 1, 32'h8000_0180);
        idle();                              lit("all_idle", 6'b000000, 0, 0, 0, 32'h8000_0180);

        // Async reset between edges during BUSY
        drive(0, 1, 6'd6, 0, 32'h0); lit("rb_start", 6'b001111, 1, 0, 0, 32'h8000_0180);
        idle();                      lit("rb_busy", 6'b001111, 1, 0, 0, 32'h8000_0180);
        #2; rst = 1'b1; #1;
        lit("rb_async", 6'b000000, 0, 0, 0, 32'h0);
        @(posedge clk); #6; rst = 1'b0;
        idle();                      lit("rb_idle", 6'b000000, 0, 0, 0, 32'h0);
        drive(1, 0, 6'd0, 0, 32'h0); lit("rb_ldu", 6'b000111, 0, 0, 0, 32'h0);

        // Async reset mid-FLUSH: pulse dropped, not replayed
        drive(0, 0, 6'd0, 1, 32'h1234_5678); lit("rf_req", 6'b000000, 0, 0, 0, 32'h0);
        idle();                              lit("rf_flush", 6'b000000, 0, 0, 1, 32'h1234_5678);
        #2; rst = 1'b1; #1;
        lit("rf_async", 6'b000000, 0, 0, 0, 32'h0);
        @(posedge clk); #6; rst = 1'b0;
        idle();                              lit("rf_idle", 6'b000000, 0, 0, 0, 32'h0);

        @(posedge clk); #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
